// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous-read RAM between an instruction-fetch port (read only)
// and a data port (load/store). One access is in flight at a time; ties are
// resolved round-robin.
//
// Ports
//   CLOCK_50                 sole clock, rising edge
//   KEY0                     synchronous active-low reset
//   if_req/if_addr           fetch request and word address
//   if_gnt/if_rvalid         one-cycle accept / read-data-valid pulses
//   if_rdata                 fetch read data, holds between rvalid pulses
//   d_req/d_we/d_addr/d_wdata  data-port request (d_we=1 store, 0 load)
//   d_gnt/d_rvalid/d_rdata   data-port accept / load-valid / load data
//   mem_addr/mem_we/mem_wdata  registered RAM command
//   mem_rdata                RAM read data, valid the cycle after mem_addr
//   err_oob                  pulses with gnt when the granted address >= DEPTH
//
// state  | meaning
// IDLE   | pick a winner from pending requests, register the RAM command
// ACCESS | gnt pulse; stores strobe mem_we this cycle and finish here
// RESP   | mem_rdata valid; rvalid pulse, read data captured for holding
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DEPTH = 3000,
    parameter int AW    = 12
) (
    input  logic          CLOCK_50,
    input  logic          KEY0,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          err_oob
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q;
    logic          last_d_q;     // 1 = data port was granted most recently
    logic          win_d_q;      // owner of the access in flight
    logic          wr_q;
    logic          oob_q;
    logic          if_gnt_q;
    logic          d_gnt_q;
    logic          if_rvalid_q;
    logic          d_rvalid_q;
    logic          err_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;

    logic          sel_data;
    logic [AW-1:0] sel_addr;
    logic          sel_oob;
    logic [31:0]   resp_data;

    // Data wins when it is the only requester, or on a tie when fetch was
    // granted last.
    always_comb begin
        sel_data  = d_req && (!if_req || !last_d_q);
        sel_addr  = sel_data ? d_addr : if_addr;
        sel_oob   = (32'(sel_addr) >= 32'(DEPTH));
        resp_data = oob_q ? 32'd0 : mem_rdata;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            win_d_q     <= 1'b0;
            wr_q        <= 1'b0;
            oob_q       <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        state_q     <= ACCESS;
                        win_d_q     <= sel_data;
                        last_d_q    <= sel_data;
                        wr_q        <= sel_data && d_we;
                        oob_q       <= sel_oob;
                        if_gnt_q    <= !sel_data;
                        d_gnt_q     <= sel_data;
                        err_q       <= sel_oob;
                        mem_addr_q  <= sel_addr;
                        mem_we_q    <= sel_data && d_we && !sel_oob;
                        mem_wdata_q <= sel_data ? d_wdata : 32'd0;
                    end
                end
                ACCESS: begin
                    if (wr_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q     <= RESP;
                        if_rvalid_q <= !win_d_q;
                        d_rvalid_q  <= win_d_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (win_d_q) d_rdata_q  <= resp_data;
                    else         if_rdata_q <= resp_data;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign err_oob   = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

    // RAM data only arrives during RESP, so the rvalid cycle passes it straight
    // through; the registered copy holds it afterwards.
    assign if_rdata = if_rvalid_q ? resp_data : if_rdata_q;
    assign d_rdata  = d_rvalid_q  ? resp_data : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int DEPTH = 3000;
    localparam int AW    = 12;

    logic          CLOCK_50;
    logic          KEY0;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          err_oob;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] shadow [int];
    logic [31:0] last_if;
    logic [31:0] last_d;

    logic [31:0] ram     [0:(1<<AW)-1];
    bit          written [0:(1<<AW)-1];

    mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY0     (KEY0),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err_oob  (err_oob)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Unwritten words read as addr+2, so RAM[5] = 7.
    function automatic logic [31:0] init_word(int a);
        return 32'(a) + 32'd2;
    endfunction

    function automatic logic [31:0] exp_rd(int a);
        if (shadow.exists(a)) return shadow[a];
        return init_word(a);
    endfunction

    // Synchronous-read RAM: data appears the cycle after the address.
    always @(posedge CLOCK_50) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any read response.
    task automatic tick();
        resp_t e;
        @(negedge CLOCK_50);
        if (if_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_port", {30'd0, if_rvalid, d_rvalid}, e.is_d ? 32'd1 : 32'd2);
                chk("rdata", e.is_d ? d_rdata : if_rdata, e.data);
                if (e.is_d) last_d = e.data;
                else        last_if = e.data;
            end
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_if_gnt"},    32'(if_gnt),    32'd0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, "_if_rdata"},  if_rdata,       32'd0);
        chk({tag, "_d_gnt"},     32'(d_gnt),     32'd0);
        chk({tag, "_d_rvalid"},  32'(d_rvalid),  32'd0);
        chk({tag, "_d_rdata"},   d_rdata,        32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_err_oob"},   32'(err_oob),   32'd0);
    endtask

    task automatic do_reset(int n, string tag);
        KEY0   = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        repeat (n) tick();
        check_zero(tag);
        KEY0 = 1'b1;
        sb.delete();
        last_if = 32'd0;
        last_d  = 32'd0;
    endtask

    // One uncontended access, starting at a falling edge in IDLE.
    task automatic single(bit is_d, bit we, logic [AW-1:0] addr, logic [31:0] wd, string tag);
        bit oob;
        oob = (int'(addr) >= DEPTH);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if (!we) sb.push_back('{is_d: is_d, data: (oob ? 32'd0 : exp_rd(int'(addr)))});
        tick();
        chk({tag, "_gnt"},      {30'd0, if_gnt, d_gnt}, is_d ? 32'd1 : 32'd2);
        chk({tag, "_err_oob"},  32'(err_oob), 32'(oob));
        chk({tag, "_mem_we"},   32'(mem_we),  32'(we && !oob));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
        if (we && !oob) chk({tag, "_mem_wdata"}, mem_wdata, wd);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if (we && !oob) shadow[int'(addr)] = wd;
        tick();
        chk({tag, "_gnt_off"},    {30'd0, if_gnt, d_gnt}, 32'd0);
        chk({tag, "_mem_we_off"}, 32'(mem_we), 32'd0);
        if (!we) begin
            chk({tag, "_rvalid_on"}, {30'd0, if_rvalid, d_rvalid}, is_d ? 32'd1 : 32'd2);
            tick();
        end
        chk({tag, "_rvalid_off"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk({tag, "_if_hold"}, if_rdata, last_if);
        chk({tag, "_d_hold"},  d_rdata,  last_d);
    endtask

    initial begin : stim
        int ng;
        int c;
        int gcyc [3];
        bit gd   [3];

        KEY0 = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        last_if = 32'd0; last_d = 32'd0;

        do_reset(2, "rst0");
        tick();
        single(1'b0, 1'b0, 12'd5, 32'd0, "fetch_rd5");
        chk("fetch_rd5_value", if_rdata, 32'h0000_0007);

        // Tie straight after reset: fetch, data, fetch.
        do_reset(1, "rst1");
        if_req = 1'b1; if_addr = 12'd20;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 12'd30;
        sb.push_back('{is_d: 1'b0, data: exp_rd(20)});
        sb.push_back('{is_d: 1'b1, data: exp_rd(30)});
        sb.push_back('{is_d: 1'b0, data: exp_rd(20)});
        ng = 0; c = 0;
        gd[0] = 1'b0; gd[1] = 1'b0; gd[2] = 1'b0;
        gcyc[0] = 0; gcyc[1] = 0; gcyc[2] = 0;
        while (ng < 3 && c < 20) begin
            tick();
            c++;
            if (if_gnt || d_gnt) begin
                chk("tie_onehot", 32'(if_gnt && d_gnt), 32'd0);
                gd[ng]   = d_gnt;
                gcyc[ng] = c;
                ng++;
                if (ng == 3) begin
                    if_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        chk("tie_grant_count", ng, 3);
        chk("tie_1st_fetch", 32'(gd[0]), 32'd0);
        chk("tie_2nd_data",  32'(gd[1]), 32'd1);
        chk("tie_3rd_fetch", 32'(gd[2]), 32'd0);
        chk("tie_1st_cycle", gcyc[0], 1);
        chk("tie_spacing_a", gcyc[1] - gcyc[0], 3);
        chk("tie_spacing_b", gcyc[2] - gcyc[1], 3);
        tick();
        tick();
        chk("tie_sb_drained", sb.size(), 0);

        // Store then load, in-range boundary, out-of-range store and load.
        single(1'b1, 1'b1, 12'd10,   32'hDEAD_BEEF, "st10");
        single(1'b1, 1'b0, 12'd10,   32'd0,         "ld10");
        chk("ld10_value", d_rdata, 32'hDEAD_BEEF);
        single(1'b1, 1'b0, 12'd2999, 32'd0,         "ld2999");
        single(1'b1, 1'b1, 12'd3000, 32'h1234_5678, "st_oob");
        single(1'b1, 1'b0, 12'd4095, 32'd0,         "ld_oob");
        chk("ld_oob_value", d_rdata, 32'd0);
        single(1'b1, 1'b0, 12'd3000, 32'd0,         "ld3000");
        single(1'b0, 1'b0, 12'd10,   32'd0,         "fetch_rd10");
        chk("fetch_rd10_value", if_rdata, 32'hDEAD_BEEF);

        // Reset sampled at the end of ACCESS: the read never responds.
        if_req = 1'b1; if_addr = 12'd7;
        tick();
        chk("rstA_gnt", 32'(if_gnt), 32'd1);
        if_req = 1'b0;
        do_reset(2, "rstA");

        // Reset during RESP: nothing pulses after the reset edge.
        if_req = 1'b1; if_addr = 12'd9;
        sb.push_back('{is_d: 1'b0, data: exp_rd(9)});
        tick();
        chk("rstB_gnt", 32'(if_gnt), 32'd1);
        if_req = 1'b0;
        tick();
        chk("rstB_rvalid_in_resp", 32'(if_rvalid), 32'd1);
        do_reset(1, "rstB");
        tick();
        chk("rstB_no_rvalid", 32'(if_rvalid), 32'd0);

        // Next tie after that reset goes to fetch.
        if_req = 1'b1; if_addr = 12'd1;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 12'd2;
        sb.push_back('{is_d: 1'b0, data: exp_rd(1)});
        tick();
        chk("post_rst_tie", {30'd0, if_gnt, d_gnt}, 32'd2);
        if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        chk("post_rst_sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
